// File: rtl/plca_rx_cmd_decoder.sv
// Receive-side PLCA request decoder: classifies MII receive samples and turns
// BEACON/COMMIT request encodings into rx_cmd / receiving, with error counting.
module plca_rx_cmd_decoder #(
  parameter int BEACON_MIN = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             plca_en,
  input  logic [3:0]       RXD,
  input  logic             RX_DV,
  input  logic             RX_ER,
  output logic [1:0]       rx_cmd,
  output logic             receiving,
  output logic             beacon_det,
  output logic             commit_det,
  output logic [ERR_W-1:0] beacon_cnt,
  output logic [ERR_W-1:0] rx_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BCN_QUAL,
    S_BEACON,
    S_COMMIT,
    S_DATA
  } state_t;

  localparam logic [1:0] CMD_BEACON = 2'b00;
  localparam logic [1:0] CMD_COMMIT = 2'b01;
  localparam logic [1:0] CMD_NONE   = 2'b10;
  localparam logic [3:0] QMIN       = 4'(BEACON_MIN);
  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       qcnt_q, qcnt_d;
  logic [3:0]       qcntInc;
  logic [1:0]       rx_cmd_q, rx_cmd_d;
  logic             receiving_q, receiving_d;
  logic             beacon_det_q, beacon_det_d;
  logic             commit_det_q, commit_det_d;
  logic [ERR_W-1:0] beacon_cnt_q, beacon_cnt_d;
  logic [ERR_W-1:0] rx_err_cnt_q, rx_err_cnt_d;
  logic [ERR_W:0]   errSum;
  logic [1:0]       errInc;

  logic             sampB, sampC, sampX, sampD;
  state_t           idleNext;
  logic [3:0]       idleQcnt;
  logic             idleErr;

  assign sampD = RX_DV;
  assign sampB = !RX_DV && RX_ER && (RXD == 4'h2);
  assign sampC = !RX_DV && RX_ER && (RXD == 4'h3);
  assign sampX = !RX_DV && RX_ER && (RXD != 4'h2) && (RXD != 4'h3);
  assign qcntInc = qcnt_q + 4'd1;

  // How IDLE would treat the current sample; several states fall back to this.
  always_comb begin
    idleNext = S_IDLE;
    idleQcnt = 4'd0;
    idleErr  = 1'b0;
    if (sampD) begin
      idleNext = S_DATA;
    end else if (sampC) begin
      idleNext = S_COMMIT;
    end else if (sampB) begin
      if (QMIN == 4'd1) begin
        idleNext = S_BEACON;
      end else begin
        idleNext = S_BCN_QUAL;
        idleQcnt = 4'd1;
      end
    end else if (sampX) begin
      idleErr = 1'b1;
    end
  end

  // A short beacon ending in an X sample counts two errors in one cycle.
  always_comb begin
    state_d = state_q;
    qcnt_d  = 4'd0;
    errInc  = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        state_d = idleNext;
        qcnt_d  = idleQcnt;
        errInc  = {1'b0, idleErr};
      end
      S_BCN_QUAL: begin
        if (sampB) begin
          if (qcntInc >= QMIN) begin
            state_d = S_BEACON;
          end else begin
            qcnt_d = qcntInc;
          end
        end else begin
          state_d = idleNext;
          qcnt_d  = idleQcnt;
          errInc  = 2'd1 + {1'b0, idleErr};
        end
      end
      S_BEACON: begin
        if (sampB)      state_d = S_BEACON;
        else if (sampC) state_d = S_COMMIT;
        else if (sampD) state_d = S_DATA;
        else            state_d = S_IDLE;
      end
      S_COMMIT: begin
        if (sampC) begin
          state_d = S_COMMIT;
        end else if (sampB) begin
          state_d = idleNext;
          qcnt_d  = idleQcnt;
        end else if (sampD) begin
          state_d = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (sampD) begin
          state_d = S_DATA;
          errInc  = {1'b0, RX_ER};
        end else begin
          state_d = idleNext;
          qcnt_d  = idleQcnt;
          errInc  = {1'b0, idleErr};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!plca_en) begin
      state_d = S_IDLE;
      qcnt_d  = 4'd0;
      errInc  = 2'd0;
    end
  end

  always_comb begin
    rx_cmd_d     = CMD_NONE;
    receiving_d  = (state_d == S_DATA);
    beacon_det_d = (state_d == S_BEACON) && (state_q != S_BEACON);
    commit_det_d = (state_d == S_COMMIT) && (state_q != S_COMMIT);
    if (state_d == S_BEACON)      rx_cmd_d = CMD_BEACON;
    else if (state_d == S_COMMIT) rx_cmd_d = CMD_COMMIT;

    beacon_cnt_d = beacon_cnt_q;
    if (beacon_det_d && (beacon_cnt_q != CNT_MAX)) begin
      beacon_cnt_d = beacon_cnt_q + 1'b1;
    end

    errSum       = {1'b0, rx_err_cnt_q} + (ERR_W + 1)'(errInc);
    rx_err_cnt_d = errSum[ERR_W] ? CNT_MAX : errSum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      qcnt_q       <= 4'd0;
      rx_cmd_q     <= CMD_NONE;
      receiving_q  <= 1'b0;
      beacon_det_q <= 1'b0;
      commit_det_q <= 1'b0;
      beacon_cnt_q <= '0;
      rx_err_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      rx_cmd_q     <= rx_cmd_d;
      receiving_q  <= receiving_d;
      beacon_det_q <= beacon_det_d;
      commit_det_q <= commit_det_d;
      beacon_cnt_q <= beacon_cnt_d;
      rx_err_cnt_q <= rx_err_cnt_d;
    end
  end

  assign rx_cmd     = rx_cmd_q;
  assign receiving  = receiving_q;
  assign beacon_det = beacon_det_q;
  assign commit_det = commit_det_q;
  assign beacon_cnt = beacon_cnt_q;
  assign rx_err_cnt = rx_err_cnt_q;

endmodule

// File: tb/tb_plca_rx_cmd_decoder.sv
// Randomized self-checking bench for plca_rx_cmd_decoder: a per-sample-class
// behavioural model is compared every cycle, plus directed literal scenarios.
module tb_plca_rx_cmd_decoder;

  localparam int BEACON_MIN = 4;
  localparam int ERR_W      = 8;
  localparam int CNT_MAX    = (1 << ERR_W) - 1;

  localparam int K_I   = 0;
  localparam int K_B   = 1;
  localparam int K_C   = 2;
  localparam int K_X   = 3;
  localparam int K_D   = 4;
  localparam int K_DER = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             plca_en;
  logic [3:0]       RXD;
  logic             RX_DV;
  logic             RX_ER;
  logic [1:0]       rx_cmd;
  logic             receiving;
  logic             beacon_det;
  logic             commit_det;
  logic [ERR_W-1:0] beacon_cnt;
  logic [ERR_W-1:0] rx_err_cnt;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  // Model view: which command (if any) is active, whether a frame is running,
  // and how many B samples the current qualifying run has seen so far.
  bit mBeacon, mCommit, mData, mBdet, mCdet;
  int mQual, mBcnt, mEcnt;

  plca_rx_cmd_decoder #(.BEACON_MIN(BEACON_MIN), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n), .plca_en(plca_en),
    .RXD(RXD), .RX_DV(RX_DV), .RX_ER(RX_ER),
    .rx_cmd(rx_cmd), .receiving(receiving),
    .beacon_det(beacon_det), .commit_det(commit_det),
    .beacon_cnt(beacon_cnt), .rx_err_cnt(rx_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Reference behaviour, organised by what kind of sample arrives.
  always @(posedge clk) begin
    bit isB, isC, isX, isD, nb, nc, nd;
    int nq, errs;
    if (!reset_n) begin
      mBeacon = 0; mCommit = 0; mData = 0; mBdet = 0; mCdet = 0;
      mQual = 0; mBcnt = 0; mEcnt = 0;
    end else if (!plca_en) begin
      mBeacon = 0; mCommit = 0; mData = 0; mBdet = 0; mCdet = 0;
      mQual = 0;
    end else begin
      isD = RX_DV;
      isB = !RX_DV && RX_ER && RXD == 4'h2;
      isC = !RX_DV && RX_ER && RXD == 4'h3;
      isX = !RX_DV && RX_ER && !isB && !isC;
      nb = 0; nc = 0; nd = 0; nq = 0;
      errs = (mQual > 0 && !isB) ? 1 : 0;
      if (isD) begin
        nd = 1;
        if (mData && RX_ER) errs++;
      end else if (isC) begin
        nc = 1;
      end else if (isB) begin
        if (mBeacon) nb = 1;
        else begin
          nq = mQual + 1;
          if (nq >= BEACON_MIN) begin nb = 1; nq = 0; end
        end
      end else if (isX) begin
        if (!mBeacon && !mCommit) errs++;
      end
      mBdet = nb && !mBeacon;
      mCdet = nc && !mCommit;
      if (mBdet) mBcnt = sat(mBcnt + 1);
      mEcnt = sat(mEcnt + errs);
      mBeacon = nb; mCommit = nc; mData = nd; mQual = nq;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model rx_cmd", int'(rx_cmd), mBeacon ? 0 : (mCommit ? 1 : 2));
      checkOutput("model receiving", int'(receiving), int'(mData));
      checkOutput("model beacon_det", int'(beacon_det), int'(mBdet));
      checkOutput("model commit_det", int'(commit_det), int'(mCdet));
      checkOutput("model beacon_cnt", int'(beacon_cnt), mBcnt);
      checkOutput("model rx_err_cnt", int'(rx_err_cnt), mEcnt);
    end
  end

  task automatic setSample(input int k);
    int n;
    RXD = 4'($urandom_range(0, 15));
    RX_DV = 1'b0;
    RX_ER = 1'b0;
    case (k)
      K_B: begin RX_ER = 1'b1; RXD = 4'h2; end
      K_C: begin RX_ER = 1'b1; RXD = 4'h3; end
      K_X: begin
        n = $urandom_range(0, 13);
        if (n >= 2) n += 2;
        RX_ER = 1'b1; RXD = 4'(n);
      end
      K_D:   RX_DV = 1'b1;
      K_DER: begin RX_DV = 1'b1; RX_ER = 1'b1; end
      default: ;
    endcase
  endtask

  // Present one sample, let the DUT clock it, and settle just after the edge.
  task automatic applyStimulus(input int k);
    setSample(k);
    @(posedge clk);
    #2;
  endtask

  task automatic expectOut(input string name, input int cmd, input int recv,
                           input int bdet, input int cdet);
    checkOutput({name, " rx_cmd"}, int'(rx_cmd), cmd);
    checkOutput({name, " receiving"}, int'(receiving), recv);
    checkOutput({name, " beacon_det"}, int'(beacon_det), bdet);
    checkOutput({name, " commit_det"}, int'(commit_det), cdet);
  endtask

  initial begin
    int k, len, pick;
    reset_n = 1'b0;
    plca_en = 1'b1;
    setSample(K_I);
    applyStimulus(K_I);
    applyStimulus(K_I);
    checkEn = 1'b1;
    expectOut("reset", 2, 0, 0, 0);
    checkOutput("reset beacon_cnt", int'(beacon_cnt), 0);
    checkOutput("reset rx_err_cnt", int'(rx_err_cnt), 0);
    reset_n = 1'b1;
    applyStimulus(K_I);

    // Five B then I: BEACON after the fourth B, for two cycles.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(K_B);
      expectOut($sformatf("beacon b%0d", i), (i >= 4) ? 0 : 2, 0, (i == 4) ? 1 : 0, 0);
    end
    applyStimulus(K_I);
    expectOut("beacon end", 2, 0, 0, 0);
    checkOutput("beacon cnt", int'(beacon_cnt), 1);

    // Short beacon.
    for (int i = 1; i <= 3; i++) applyStimulus(K_B);
    expectOut("short b3", 2, 0, 0, 0);
    applyStimulus(K_I);
    checkOutput("short err", int'(rx_err_cnt), 1);
    checkOutput("short bcnt", int'(beacon_cnt), 1);

    // Beacon, commit, frame.
    for (int i = 1; i <= 4; i++) applyStimulus(K_B);
    expectOut("bcf beacon", 0, 0, 1, 0);
    applyStimulus(K_C);
    expectOut("bcf c1", 1, 0, 0, 1);
    applyStimulus(K_C);
    expectOut("bcf c2", 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(K_D);
      expectOut($sformatf("bcf d%0d", i), 2, 1, 0, 0);
    end
    applyStimulus(K_I);
    expectOut("bcf end", 2, 0, 0, 0);
    checkOutput("bcf bcnt", int'(beacon_cnt), 2);

    // Reset mid-beacon.
    for (int i = 1; i <= 4; i++) applyStimulus(K_B);
    reset_n = 1'b0;
    applyStimulus(K_B);
    expectOut("midreset", 2, 0, 0, 0);
    checkOutput("midreset bcnt", int'(beacon_cnt), 0);
    checkOutput("midreset err", int'(rx_err_cnt), 0);
    reset_n = 1'b1;

    // Errors then disable during a frame.
    applyStimulus(K_X);
    applyStimulus(K_X);
    applyStimulus(K_DER);
    applyStimulus(K_DER);
    checkOutput("frame err", int'(rx_err_cnt), 3);
    plca_en = 1'b0;
    applyStimulus(K_D);
    expectOut("disable", 2, 0, 0, 0);
    checkOutput("disable err hold", int'(rx_err_cnt), 3);
    plca_en = 1'b1;

    // Saturation.
    for (int i = 0; i < 300; i++) applyStimulus(K_DER);
    checkOutput("sat frame", int'(rx_err_cnt), 255);
    applyStimulus(K_I);
    for (int i = 0; i < 5; i++) applyStimulus(K_X);
    checkOutput("sat hold", int'(rx_err_cnt), 255);

    // Fresh counters, then randomized bursts.
    reset_n = 1'b0;
    applyStimulus(K_I);
    reset_n = 1'b1;
    for (int burst = 0; burst < 1500; burst++) begin
      pick = $urandom_range(0, 99);
      if (pick < 30)      k = K_B;
      else if (pick < 45) k = K_C;
      else if (pick < 60) k = K_D;
      else if (pick < 70) k = K_DER;
      else if (pick < 85) k = K_I;
      else                k = K_X;
      len = $urandom_range(1, (k == K_B) ? 7 : 4);
      plca_en = ($urandom_range(0, 99) >= 4);
      reset_n = ($urandom_range(0, 199) != 0);
      for (int j = 0; j < len; j++) begin
        applyStimulus(k);
        reset_n = 1'b1;
      end
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/plca_rx_cmd_decoder.md
# plca_rx_cmd_decoder

Receive-side counterpart of the PLCA control state machine: samples the receive MII (RXD, RX_DV, RX_ER) and decodes the PLCA BEACON and COMMIT request encodings into the `rx_cmd` and `receiving` variables consumed by the PLCA control, data and status functions. BEACON is qualified by a minimum duration. Short or unknown request encodings are counted as errors. Sits between the PHY receive MII and the PLCA RS, in the same clock domain as the MII.

## Interface
- BEACON_MIN, 4: consecutive BEACON-encoded samples required before `rx_cmd` = BEACON (legal range 1-15).
- ERR_W, 8: width of the saturating error and beacon counters.
- clk  input  1  receive MII clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- plca_en  input  1  PLCA enable; low forces idle decoding.
- RXD  input  4  receive MII data nibble.
- RX_DV  input  1  receive data valid.
- RX_ER  input  1  receive error / request-encoding qualifier.
- rx_cmd  output  2  decoded command: 2'b00 BEACON, 2'b01 COMMIT, 2'b10 NONE.
- receiving  output  1  frame reception in progress.
- beacon_det  output  1  one-cycle pulse on the first cycle `rx_cmd` becomes BEACON.
- commit_det  output  1  one-cycle pulse on the first cycle `rx_cmd` becomes COMMIT.
- beacon_cnt  output  ERR_W  saturating count of qualified BEACONs.
- rx_err_cnt  output  ERR_W  saturating count of decode errors.

## Operation
- Sample classes, decoded each cycle from RX_DV/RX_ER/RXD:
  - B: RX_DV=0, RX_ER=1, RXD=4'h2.
  - C: RX_DV=0, RX_ER=1, RXD=4'h3.
  - X: RX_DV=0, RX_ER=1, any other RXD.
  - D: RX_DV=1.
  - I: RX_DV=0, RX_ER=0.
- FSM states: IDLE, BCN_QUAL, BEACON, COMMIT, DATA. A 4-bit qualifying counter `qcnt` runs in BCN_QUAL.
- IDLE:
  - B: go to BCN_QUAL with qcnt=1. If BEACON_MIN=1, go directly to BEACON.
  - C: go to COMMIT.
  - D: go to DATA.
  - X: increment rx_err_cnt, stay in IDLE.
- BCN_QUAL:
  - B: increment qcnt. When qcnt reaches BEACON_MIN, go to BEACON.
  - Any non-B sample: this is a short beacon. Increment rx_err_cnt, then take the transition IDLE would take for that sample. A short beacon followed by D still enters DATA.
- BEACON:
  - B: stay.
  - C: go directly to COMMIT.
  - D: go to DATA.
  - I or X: go to IDLE. No error is counted.
- COMMIT:
  - C: stay.
  - B: go to BCN_QUAL with qcnt=1.
  - D: go to DATA.
  - I or X: go to IDLE.
- DATA:
  - D: stay. A cycle with RX_DV=1 and RX_ER=1 increments rx_err_cnt once per cycle.
  - Otherwise: return to IDLE on that cycle and re-evaluate the sample as IDLE would. B goes to BCN_QUAL, C goes to COMMIT.
- Outputs by state:
  - rx_cmd: BEACON in state BEACON, COMMIT in state COMMIT, NONE otherwise.
  - receiving: 1 in state DATA only.
- Entering BEACON increments beacon_cnt and pulses beacon_det. Entering COMMIT pulses commit_det.
- Counters saturate at all-ones and never wrap.
- plca_en=0: FSM forced to IDLE, qcnt cleared, rx_cmd=NONE, receiving=0, pulses 0. Counters hold their values.

## Timing
- All outputs are registered and update one clock after the sample that causes the transition.
- BEACON latency: `rx_cmd` = BEACON on the cycle after the BEACON_MIN-th consecutive B sample.
- COMMIT latency: `rx_cmd` = COMMIT one cycle after the first C sample.
- `rx_cmd` returns to NONE one cycle after the last B or C sample.
- `receiving` rises one cycle after RX_DV rises and falls one cycle after RX_DV falls.
- beacon_det and commit_det are exactly one cycle wide and coincide with the first cycle of the new `rx_cmd` value.
- A direct B→C edge produces no NONE gap: `rx_cmd` goes BEACON then COMMIT on consecutive cycles.
- Reset (reset_n=0 at a rising edge) takes priority over everything, including mid-beacon and mid-frame. Reset values:
  - state IDLE, qcnt 0
  - rx_cmd 2'b10, receiving 0, beacon_det 0, commit_det 0
  - beacon_cnt 0, rx_err_cnt 0
- plca_en takes priority over sample decoding but not over reset.
- An error event and a transition on the same sample both take effect in the same cycle.

## Test plan
- Beacon: with BEACON_MIN=4, drive 5 B samples then I → rx_cmd=BEACON on cycles 5-6 after the first B, beacon_det pulses once, beacon_cnt=1, rx_cmd=NONE on cycle 7.
- Short beacon: 3 B samples then I → rx_cmd stays NONE, rx_err_cnt=1, beacon_cnt=0.
- Beacon then commit then frame: 4 B, then 2 C, then 10 D, then I → rx_cmd goes BEACON→COMMIT with no NONE gap, commit_det pulses once, receiving is high for 10 cycles starting one cycle after the first D, then rx_cmd=NONE.
- Errors and saturation: RX_ER=1 during D for 300 cycles, plus X samples → rx_err_cnt saturates at 255 and holds.
- Reset and disable mid-operation: assert reset_n=0 during BEACON → all outputs return to reset values next cycle. Drop plca_en during DATA → receiving=0 next cycle while counters keep their values.
